// File: rtl/icache.sv
// Direct-mapped read-only instruction cache: 1-cycle hits, 4-word line refill on a miss.
// The global rdy input freezes all state. A flush suppresses the pending response but never aborts a fill.
module icache #(
    parameter int INDEX_BITS = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        flush,
    input  logic        if_enable,
    input  logic [31:0] if_pc,
    output logic        icache_success,
    output logic [31:0] instr_out,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic [31:0] mem_data,
    input  logic        mem_done
);
    localparam int LINES = 1 << INDEX_BITS;
    localparam int TAG_W = 32 - 4 - INDEX_BITS;

    typedef enum logic {IDLE, FILL} state_t;

    state_t                  state;
    logic                    valid_q [LINES];
    logic [TAG_W-1:0]        tag_q   [LINES];
    logic [31:0]             data_q  [LINES][4];
    logic [31:0]             line_buf [4];
    logic [27:0]             req_line;
    logic [1:0]              req_off;
    logic [1:0]              cnt;
    logic                    discard;

    logic [INDEX_BITS-1:0]   lk_idx;
    logic [TAG_W-1:0]        lk_tag;
    logic                    lk_hit;
    logic                    accept;
    logic [INDEX_BITS-1:0]   req_idx;
    logic [TAG_W-1:0]        req_tag;
    logic                    last_word;
    logic [31:0]             fill_word;

    assign lk_idx  = if_pc[4 +: INDEX_BITS];
    assign lk_tag  = if_pc[31 -: TAG_W];
    assign lk_hit  = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    // A request cannot be taken in the cycle a response is being presented.
    assign accept  = (state == IDLE) && if_enable && !flush && !icache_success;
    assign req_idx = req_line[INDEX_BITS-1:0];
    assign req_tag = req_line[27 -: TAG_W];
    assign last_word = (state == FILL) && mem_done && (cnt == 2'd3);
    assign fill_word = (req_off == 2'd3) ? mem_data : line_buf[req_off];

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            icache_success <= 1'b0;
            instr_out      <= 32'h0;
            mem_req        <= 1'b0;
            mem_addr       <= 32'h0;
            discard        <= 1'b0;
            cnt            <= 2'd0;
            req_line       <= 28'h0;
            req_off        <= 2'd0;
            for (int i = 0; i < LINES; i++) valid_q[i] <= 1'b0;
        end else if (rdy) begin
            icache_success <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (lk_hit) begin
                            icache_success <= 1'b1;
                            instr_out      <= data_q[lk_idx][if_pc[3:2]];
                        end else begin
                            state    <= FILL;
                            req_line <= if_pc[31:4];
                            req_off  <= if_pc[3:2];
                            mem_req  <= 1'b1;
                            mem_addr <= if_pc & 32'hFFFF_FFF0;
                            cnt      <= 2'd0;
                            discard  <= 1'b0;
                        end
                    end
                end
                FILL: begin
                    if (flush) discard <= 1'b1;
                    if (mem_done) begin
                        line_buf[cnt] <= mem_data;
                        cnt           <= cnt + 2'd1;
                        mem_addr      <= mem_addr + 32'd4;
                        if (cnt == 2'd3) begin
                            valid_q[req_idx] <= 1'b1;
                            mem_req          <= 1'b0;
                            state            <= IDLE;
                            discard          <= 1'b0;
                            if (!discard && !flush) begin
                                icache_success <= 1'b1;
                                instr_out      <= fill_word;
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Tag and data storage need no reset; the valid bits gate every use.
    always_ff @(posedge clk) begin
        if (!rst && rdy && last_word) begin
            tag_q[req_idx]     <= req_tag;
            data_q[req_idx][0] <= line_buf[0];
            data_q[req_idx][1] <= line_buf[1];
            data_q[req_idx][2] <= line_buf[2];
            data_q[req_idx][3] <= mem_data;
        end
    end
endmodule
